pc_call_unit: RTL and testbench
===============================

Name: pc_call_unit

Overview:
- Program-counter and fetch-address generator for the single-cycle core.
- Drives the 8-bit address of the instruction memory, which returns the 15-bit word (opcode [14:8], literal [7:0]) combinationally in the same cycle.
- Supports sequential increment, absolute jumps, and CALL/RET through an internal return-address stack.
- Has halt and fault states; control/decode supplies already-resolved jump/call/ret strobes.

Parameters:
- ADDR_W, 8, width of PC, jump targets and stack entries.
- STACK_DEPTH, 8, number of return-address entries (power of two, ≥2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold PC and stack this cycle.
- halt_req  input  1  enter HALT at the next edge.
- load_en  input  1  taken jump: PC <= load_addr.
- call_en  input  1  CALL: push PC+1, PC <= load_addr.
- ret_en  input  1  RET: PC <= popped entry.
- load_addr  input  ADDR_W  jump/call target, normally the instruction literal.
- pc  output  ADDR_W  current fetch address to the instruction memory.
- sp  output  $clog2(STACK_DEPTH)+1  number of valid stack entries, 0..STACK_DEPTH.
- halted  output  1  high in HALT.
- fault  output  1  high in FAULT.
- fault_code  output  2  00 none, 01 overflow, 10 underflow.

Behaviour:
- Reset (async, on rst_n low, independent of clk):
  - pc=0, sp=0, state=RUN, halted=0, fault=0, fault_code=00.
  - Stack RAM contents are not cleared and are unobservable while sp=0.
  - Reset mid-CALL/RET abandons the operation with no partial push/pop.
- States:
  - RUN: normal operation.
  - HALT: pc, sp and stack frozen; all inputs ignored; exit only by reset.
  - FAULT: as HALT, with fault=1 and fault_code latched; exit only by reset.
- RUN per-edge priority, highest first:
  1. halt_req -> HALT; pc unchanged.
  2. stall -> everything held, state unchanged.
  3. ret_en:
     - if sp==0 -> FAULT, code 10, pc held;
     - else pc <= stack[sp-1], sp <= sp-1.
  4. call_en:
     - if sp==STACK_DEPTH -> FAULT, code 01, pc held, no write;
     - else stack[sp] <= pc+1 (mod 2^ADDR_W), sp <= sp+1, pc <= load_addr.
  5. load_en -> pc <= load_addr.
  6. Otherwise pc <= pc+1.
- Simultaneous strobes follow the priority above; lower-priority strobes are discarded.
- Arithmetic and wrap-around:
  - pc increments modulo 2^ADDR_W: 255 -> 0.
  - A CALL at pc=255 pushes 0.
- Latency:
  - New pc is visible one clock after the edge that samples the strobe.
  - halted/fault/fault_code are registered and assert in the same cycle the state changes.
- pc is a register output with no combinational path from inputs; the instruction memory read is purely combinational from pc.
- Stack:
  - LIFO.
  - Push and pop never happen in the same cycle.
  - Popped entries are left in RAM.

Test Plan:
- Reset then 300 free-running cycles -> pc 0,1,…,255,0,…,43; sp=0; halted=0; fault=0.
- At pc=5: load_en with load_addr=0x40 -> next pc=0x40, then 0x41; sp unchanged.
- At pc=0x10: call_en with load_addr=0x80 -> pc=0x80, sp=1. Two cycles later, ret_en -> pc=0x11, sp=0.
- 8 nested CALLs succeed (sp=8), then a 9th call_en -> fault=1, fault_code=01, pc frozen, sp=8. A later ret_en is ignored. rst_n low -> all outputs return to reset values asynchronously.
- ret_en with sp=0 -> fault=1, fault_code=10, pc held.
- Stall, halt and priority cases:
  - stall held 3 cycles during call_en -> no push until stall drops.
  - halt_req with call_en in the same cycle -> HALT, sp unchanged, pc frozen.
  - ret_en+call_en in the same cycle with sp=2 -> RET only, sp=1.

Source files
------------

// File: rtl/pc_call_unit_if.sv
// Control strobes in, fetch address and status out, for the PC/call unit.
// Latency: none (wires only).
// Backpressure: none; stall is carried as a plain level.
interface pc_call_unit_if #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 8
);
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;

    logic              stall;
    logic              halt_req;
    logic              load_en;
    logic              call_en;
    logic              ret_en;
    logic [ADDR_W-1:0] load_addr;
    logic [ADDR_W-1:0] pc;
    logic [SP_W-1:0]   sp;
    logic              halted;
    logic              fault;
    logic [1:0]        fault_code;

    // Control/decode side: resolves the strobes and consumes the address.
    modport master (
        output stall, halt_req, load_en, call_en, ret_en, load_addr,
        input  pc, sp, halted, fault, fault_code
    );

    // The PC/call unit itself.
    modport slave (
        input  stall, halt_req, load_en, call_en, ret_en, load_addr,
        output pc, sp, halted, fault, fault_code
    );
endinterface

// File: rtl/pc_call_unit.sv
// Program counter and fetch-address generator with return-address stack.
// Latency: new pc visible one clock after the edge that samples a strobe.
// Backpressure: stall holds pc, sp and stack; HALT/FAULT freeze until reset.
module pc_call_unit #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    pc_call_unit_if.slave   bus
);
    localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
    localparam int IDX_W = $clog2(STACK_DEPTH);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HALT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [1:0]        code_q, code_d;
    logic              push_we;
    logic [ADDR_W-1:0] pc_inc;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  pop_idx;

    logic [ADDR_W-1:0] stack [STACK_DEPTH];

    // Incremented pc doubles as the return address; wraps naturally.
    assign pc_inc   = pc_q + ADDR_W'(1);
    assign push_idx = sp_q[IDX_W-1:0];
    assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

    // State, pc, sp and latched fault code; reset abandons any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            pc_q    <= '0;
            sp_q    <= '0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            code_q  <= code_d;
        end
    end

    // Stack RAM is never cleared; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (push_we && rst_n) begin
            stack[push_idx] <= pc_inc;
        end
    end

    // Next state and datapath, in strobe priority order.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        code_d  = code_q;
        push_we = 1'b0;
        if (state_q == S_RUN) begin
            if (bus.halt_req) begin
                state_d = S_HALT;
            end else if (bus.stall) begin
                state_d = S_RUN;
            end else if (bus.ret_en) begin
                if (sp_q == '0) begin
                    state_d = S_FAULT;
                    code_d  = 2'b10;
                end else begin
                    pc_d = stack[pop_idx];
                    sp_d = sp_q - SP_W'(1);
                end
            end else if (bus.call_en) begin
                if (sp_q == SP_W'(STACK_DEPTH)) begin
                    state_d = S_FAULT;
                    code_d  = 2'b01;
                end else begin
                    push_we = 1'b1;
                    sp_d    = sp_q + SP_W'(1);
                    pc_d    = bus.load_addr;
                end
            end else if (bus.load_en) begin
                pc_d = bus.load_addr;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    // Outputs straight from registered state; no input-to-output path.
    always_comb begin
        bus.pc         = pc_q;
        bus.sp         = sp_q;
        bus.halted     = (state_q == S_HALT);
        bus.fault      = (state_q == S_FAULT);
        bus.fault_code = code_q;
    end
endmodule

// File: tb/tb_pc_call_unit.sv
// Bench for pc_call_unit: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expected values.
// Inputs change #1 after posedge; outputs are sampled on negedge.
module tb_pc_call_unit;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pc_call_unit_if #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH)) bus ();

    pc_call_unit #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pc as a wrapping byte, the stack as a queue,
    // mode 0=run 1=halt 2=fault.
    logic [7:0] m_pc;
    logic [7:0] stk[$];
    int         m_mode;
    int         m_code;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc   = 8'd0;
            stk.delete();
            m_mode = 0;
            m_code = 0;
        end else if (m_mode == 0) begin
            if (bus.halt_req) begin
                m_mode = 1;
            end else if (bus.stall) begin
                m_mode = 0;
            end else if (bus.ret_en) begin
                if (stk.size() == 0) begin
                    m_mode = 2;
                    m_code = 2;
                end else begin
                    m_pc = stk.pop_back();
                end
            end else if (bus.call_en) begin
                if (stk.size() == DEPTH) begin
                    m_mode = 2;
                    m_code = 1;
                end else begin
                    stk.push_back(m_pc + 8'd1);
                    m_pc = bus.load_addr;
                end
            end else if (bus.load_en) begin
                m_pc = bus.load_addr;
            end else begin
                m_pc = m_pc + 8'd1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        checks++;
        if (bus.pc !== m_pc || int'(bus.sp) != stk.size() ||
            bus.halted !== (m_mode == 1) || bus.fault !== (m_mode == 2) ||
            int'(bus.fault_code) != m_code) begin
            failures++;
            $display("FAIL cycle t=%0t: pc=%0h sp=%0d halted=%0b fault=%0b code=%0d required pc=%0h sp=%0d halted=%0b fault=%0b code=%0d",
                     $time, bus.pc, bus.sp, bus.halted, bus.fault, bus.fault_code,
                     m_pc, stk.size(), (m_mode == 1), (m_mode == 2), m_code);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall     = 1'b0;
        bus.halt_req  = 1'b0;
        bus.load_en   = 1'b0;
        bus.call_en   = 1'b0;
        bus.ret_en    = 1'b0;
        bus.load_addr = '0;
    endtask

    // Called #1 after a posedge; pulse stays well clear of the next edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("async_rst_pc", int'(bus.pc), 0);
        chk("async_rst_sp", int'(bus.sp), 0);
        chk("async_rst_fault", int'(bus.fault), 0);
        chk("async_rst_halted", int'(bus.halted), 0);
        chk("async_rst_code", int'(bus.fault_code), 0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        chk("reset_pc", int'(bus.pc), 0);
        chk("reset_sp", int'(bus.sp), 0);

        // Free-running count with wrap.
        tick(299);
        chk("free_run_299", int'(bus.pc), 43);
        tick(212);
        chk("pre_wrap", int'(bus.pc), 255);
        tick(1);
        chk("wrap_to_0", int'(bus.pc), 0);

        // Jump.
        tick(5);
        chk("at_5", int'(bus.pc), 5);
        bus.load_en = 1'b1; bus.load_addr = 8'h40;
        tick(1); idle();
        chk("jump_0x40", int'(bus.pc), 8'h40);
        tick(1);
        chk("after_jump", int'(bus.pc), 8'h41);
        chk("jump_sp", int'(bus.sp), 0);

        // CALL then RET.
        bus.load_en = 1'b1; bus.load_addr = 8'h10;
        tick(1); idle();
        bus.call_en = 1'b1; bus.load_addr = 8'h80;
        tick(1); idle();
        chk("call_pc", int'(bus.pc), 8'h80);
        chk("call_sp", int'(bus.sp), 1);
        tick(2);
        bus.ret_en = 1'b1;
        tick(1); idle();
        chk("ret_pc", int'(bus.pc), 8'h11);
        chk("ret_sp", int'(bus.sp), 0);

        // Eight nested calls, then overflow.
        for (int i = 0; i < DEPTH; i++) begin
            bus.call_en = 1'b1; bus.load_addr = 8'(8'h20 + i);
            tick(1);
        end
        idle();
        chk("nest_sp", int'(bus.sp), 8);
        chk("nest_pc", int'(bus.pc), 8'h27);
        bus.call_en = 1'b1; bus.load_addr = 8'h55;
        tick(1); idle();
        chk("ovf_fault", int'(bus.fault), 1);
        chk("ovf_code", int'(bus.fault_code), 1);
        chk("ovf_pc", int'(bus.pc), 8'h27);
        chk("ovf_sp", int'(bus.sp), 8);
        bus.ret_en = 1'b1;
        tick(1); idle();
        chk("fault_ret_ignored_pc", int'(bus.pc), 8'h27);
        chk("fault_ret_ignored_sp", int'(bus.sp), 8);
        do_reset();

        // Underflow.
        bus.ret_en = 1'b1;
        tick(1); idle();
        chk("unf_fault", int'(bus.fault), 1);
        chk("unf_code", int'(bus.fault_code), 2);
        chk("unf_pc", int'(bus.pc), 0);
        tick(2);
        do_reset();

        // Stall holds a pending call.
        tick(3);
        chk("pre_stall_pc", int'(bus.pc), 3);
        bus.stall = 1'b1; bus.call_en = 1'b1; bus.load_addr = 8'h90;
        tick(3);
        chk("stall_pc", int'(bus.pc), 3);
        chk("stall_sp", int'(bus.sp), 0);
        bus.stall = 1'b0;
        tick(1); idle();
        chk("unstall_pc", int'(bus.pc), 8'h90);
        chk("unstall_sp", int'(bus.sp), 1);

        // RET wins over CALL with sp=2.
        bus.call_en = 1'b1; bus.load_addr = 8'hA0;
        tick(1); idle();
        chk("sp2", int'(bus.sp), 2);
        bus.ret_en = 1'b1; bus.call_en = 1'b1; bus.load_addr = 8'hB0;
        tick(1); idle();
        chk("prio_pc", int'(bus.pc), 8'h91);
        chk("prio_sp", int'(bus.sp), 1);

        // HALT wins over CALL and then freezes everything.
        bus.halt_req = 1'b1; bus.call_en = 1'b1; bus.load_addr = 8'hC0;
        tick(1); idle();
        chk("halt_flag", int'(bus.halted), 1);
        chk("halt_pc", int'(bus.pc), 8'h91);
        chk("halt_sp", int'(bus.sp), 1);
        bus.load_en = 1'b1; bus.load_addr = 8'h33;
        tick(2); idle();
        chk("halt_frozen_pc", int'(bus.pc), 8'h91);
        do_reset();

        // CALL at pc=255 pushes 0.
        bus.load_en = 1'b1; bus.load_addr = 8'hFF;
        tick(1); idle();
        bus.call_en = 1'b1; bus.load_addr = 8'h12;
        tick(1); idle();
        chk("call255_pc", int'(bus.pc), 8'h12);
        bus.ret_en = 1'b1;
        tick(1); idle();
        chk("ret_wrap_pc", int'(bus.pc), 0);
        chk("ret_wrap_sp", int'(bus.sp), 0);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
